pdp_image_loader: RTL

PDP_IMAGE_LOADER -- requirements
Module: pdp_image_loader

---
 rtl/pdp_image_loader.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pdp_image_loader.sv
// Octal paper-tape style image loader: parses '*' (start PC), '@' (address) and '-' (data word)
// records from an ASCII byte stream into word writes. Optional checksum output: LOADER_CHECKSUM_EN.
module pdp_image_loader #(
  parameter logic [15:0] LOAD_BASE = 16'o000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  output logic [15:0] start_pc,
  output logic        start_valid,
  output logic [15:0] word_count,
  output logic        done,
  output logic        err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_NUM    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] T_START = 2'd0;
  localparam logic [1:0] T_ADDR  = 2'd1;
  localparam logic [1:0] T_DATA  = 2'd2;

  logic [1:0]   r_state, w_state_n;
  logic [1:0]   r_type, w_type_n;
  logic [W-1:0] r_acc, w_acc_n;
  logic         r_has_dig, w_has_dig_n;
  logic [W-1:0] r_addr, w_addr_n;
  logic         r_last, w_last_n;
  logic         r_mem_we, w_mem_we_n;
  logic [W-1:0] r_mem_addr, w_mem_addr_n;
  logic [W-1:0] r_mem_wdata, w_mem_wdata_n;
  logic [W-1:0] r_start_pc, w_start_pc_n;
  logic         r_start_valid, w_start_valid_n;
  logic [W-1:0] r_word_count, w_word_count_n;
  logic         r_done, w_done_n;
  logic         r_err, w_err_n;
`ifdef LOADER_CHECKSUM_EN
  logic [W-1:0] r_csum, w_csum_n;
`endif

  logic         w_is_ws, w_is_sym, w_is_dig, w_fire;
  logic [1:0]   w_sym_type;
  logic         w_close, w_close_dig, w_close_last;
  logic [1:0]   w_close_type;
  logic [W-1:0] w_close_acc;

  assign w_is_ws  = (in_data == 8'h20) || (in_data == 8'h09) || (in_data == 8'h0A) || (in_data == 8'h0D);
  assign w_is_sym = (in_data == 8'h2A) || (in_data == 8'h40) || (in_data == 8'h2D);
  assign w_is_dig = (in_data >= 8'h30) && (in_data <= 8'h37);
  assign w_sym_type = (in_data == 8'h2A) ? T_START : ((in_data == 8'h40) ? T_ADDR : T_DATA);

  // A symbol arriving in NUM terminates the record but is left for IDLE to consume.
  assign in_ready = (r_state == S_IDLE) || ((r_state == S_NUM) && !(in_valid && w_is_sym));
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    w_state_n       = r_state;
    w_type_n        = r_type;
    w_acc_n         = r_acc;
    w_has_dig_n     = r_has_dig;
    w_addr_n        = r_addr;
    w_last_n        = r_last;
    w_mem_we_n      = r_mem_we;
    w_mem_addr_n    = r_mem_addr;
    w_mem_wdata_n   = r_mem_wdata;
    w_start_pc_n    = r_start_pc;
    w_start_valid_n = 1'b0;
    w_word_count_n  = r_word_count;
    w_err_n         = r_err;
`ifdef LOADER_CHECKSUM_EN
    w_csum_n        = r_csum;
`endif
    w_close         = 1'b0;
    w_close_type    = r_type;
    w_close_acc     = r_acc;
    w_close_dig     = r_has_dig;
    w_close_last    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          if (w_is_sym) begin
            w_type_n    = w_sym_type;
            w_acc_n     = '0;
            w_has_dig_n = 1'b0;
            w_state_n   = S_NUM;
            if (in_last) begin
              w_close      = 1'b1;
              w_close_type = w_sym_type;
              w_close_acc  = '0;
              w_close_dig  = 1'b0;
              w_close_last = 1'b1;
            end
          end else if (!w_is_ws) begin
            w_err_n = 1'b1;
            if (in_last) w_state_n = S_DONE;
          end else if (in_last) begin
            w_state_n = S_DONE;
          end
        end
      end
      S_NUM: begin
        if (in_valid) begin
          if (w_is_sym) begin
            w_close = 1'b1;
          end else if (w_is_dig) begin
            w_acc_n     = {r_acc[12:0], in_data[2:0]};
            w_has_dig_n = 1'b1;
            if (in_last) begin
              w_close      = 1'b1;
              w_close_acc  = {r_acc[12:0], in_data[2:0]};
              w_close_dig  = 1'b1;
              w_close_last = 1'b1;
            end
          end else if (w_is_ws) begin
            w_close      = 1'b1;
            w_close_last = in_last;
          end else begin
            w_err_n   = 1'b1;
            w_state_n = in_last ? S_DONE : S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        if (mem_ready) begin
          w_mem_we_n     = 1'b0;
          w_addr_n       = r_addr + W'(2);
          w_word_count_n = r_word_count + W'(1);
`ifdef LOADER_CHECKSUM_EN
          w_csum_n       = r_csum + r_mem_wdata;
`endif
          w_state_n      = r_last ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
      end
    endcase

    // Record close: act on the accumulated value according to the record type.
    if (w_close) begin
      if (!w_close_dig) begin
        w_err_n   = 1'b1;
        w_state_n = w_close_last ? S_DONE : S_IDLE;
      end else begin
        case (w_close_type)
          T_START: begin
            w_start_pc_n    = w_close_acc;
            w_start_valid_n = 1'b1;
            w_state_n       = w_close_last ? S_DONE : S_IDLE;
          end
          T_ADDR: begin
            w_addr_n  = {w_close_acc[W-1:1], 1'b0};
            if (w_close_acc[0]) w_err_n = 1'b1;
            w_state_n = w_close_last ? S_DONE : S_IDLE;
          end
          default: begin
            w_mem_we_n    = 1'b1;
            w_mem_addr_n  = r_addr;
            w_mem_wdata_n = w_close_acc;
            w_last_n      = w_close_last;
            w_state_n     = S_COMMIT;
          end
        endcase
      end
    end

    w_done_n = r_done || (w_state_n == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_type        <= T_DATA;
      r_acc         <= '0;
      r_has_dig     <= 1'b0;
      r_addr        <= LOAD_BASE;
      r_last        <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_start_pc    <= '0;
      r_start_valid <= 1'b0;
      r_word_count  <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_state       <= w_state_n;
      r_type        <= w_type_n;
      r_acc         <= w_acc_n;
      r_has_dig     <= w_has_dig_n;
      r_addr        <= w_addr_n;
      r_last        <= w_last_n;
      r_mem_we      <= w_mem_we_n;
      r_mem_addr    <= w_mem_addr_n;
      r_mem_wdata   <= w_mem_wdata_n;
      r_start_pc    <= w_start_pc_n;
      r_start_valid <= w_start_valid_n;
      r_word_count  <= w_word_count_n;
      r_done        <= w_done_n;
      r_err         <= w_err_n;
`ifdef LOADER_CHECKSUM_EN
      r_csum        <= w_csum_n;
`endif
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign start_pc    = r_start_pc;
  assign start_valid = r_start_valid;
  assign word_count  = r_word_count;
  assign done        = r_done;
  assign err         = r_err;
`ifdef LOADER_CHECKSUM_EN
  assign checksum    = r_csum;
`endif

endmodule
